// File: rtl/rgb_roi_streamer_if.sv
// rgb_roi_streamer_if: upstream FIFO read port, downstream FIFO write port and frame pulse
interface rgb_roi_streamer_if;
    logic        in_rd_en;
    logic        in_empty;
    logic [23:0] in_dout;
    logic        out_wr_en;
    logic        out_full;
    logic [7:0]  out_din;
    logic        frame_done;
    modport master (
        output in_rd_en,
        input  in_empty,
        input  in_dout,
        output out_wr_en,
        input  out_full,
        output out_din,
        output frame_done
    );
    modport slave (
        input  in_rd_en,
        output in_empty,
        output in_dout,
        input  out_wr_en,
        output out_full,
        input  out_din,
        input  frame_done
    );
endinterface

// File: rtl/rgb_roi_streamer.sv
// rgb_roi_streamer: raster RGB to grayscale, forwarding only region-of-interest pixels
module rgb_roi_streamer #(
    parameter int WIDTH          = 720,
    parameter int HEIGHT         = 540,
    parameter int STARTING_X     = 160,
    parameter int STARTING_Y     = 270,
    parameter int REDUCED_WIDTH  = 400,
    parameter int REDUCED_HEIGHT = 270
) (
    input logic clock,
    input logic reset,
    rgb_roi_streamer_if.master bus
);
    localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] X_LO  = XW'(STARTING_X);
    localparam logic [XW-1:0] X_HI  = XW'(STARTING_X + REDUCED_WIDTH - 1);
    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LO  = YW'(STARTING_Y);
    localparam logic [YW-1:0] Y_HI  = YW'(STARTING_Y + REDUCED_HEIGHT - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          hold_valid_q, hold_valid_d;
    logic [7:0]    hold_data_q, hold_data_d;
    logic          frame_done_q, frame_done_d;
    logic          rd, wr, in_roi, x_wrap, y_wrap;
    logic [9:0]    sum;
    logic [7:0]    gray;
    // Read gating, grayscale conversion and next state of counters and holding register
    always_comb begin
        wr           = hold_valid_q & !bus.out_full;
        rd           = !reset & !bus.in_empty & (!hold_valid_q | !bus.out_full);
        in_roi       = (x_q >= X_LO) & (x_q <= X_HI) & (y_q >= Y_LO) & (y_q <= Y_HI);
        sum          = {2'b00, bus.in_dout[23:16]} + {2'b00, bus.in_dout[15:8]} + {2'b00, bus.in_dout[7:0]};
        gray         = 8'(sum / 10'd3);
        x_wrap       = x_q == X_MAX;
        y_wrap       = y_q == Y_MAX;
        x_d          = rd ? (x_wrap ? '0 : x_q + 1'b1) : x_q;
        y_d          = (rd & x_wrap) ? (y_wrap ? '0 : y_q + 1'b1) : y_q;
        hold_valid_d = (rd & in_roi) ? 1'b1 : (wr ? 1'b0 : hold_valid_q);
        hold_data_d  = (rd & in_roi) ? gray : hold_data_q;
        frame_done_d = rd & x_wrap & y_wrap;
    end
    // State registers; a reset drops any held pixel without writing it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            frame_done_q <= frame_done_d;
        end
    end
    assign bus.in_rd_en   = rd;
    assign bus.out_wr_en  = wr;
    assign bus.out_din    = hold_data_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: doc/rgb_roi_streamer.md
Name: rgb_roi_streamer

Overview:
Front-end producer for the blur input FIFO. It reads full-frame 24-bit RGB pixels in raster order from an upstream FIFO and converts each to 8-bit grayscale. Only pixels inside the reduced region of interest are written to the downstream FIFO. The block emits exactly REDUCED_WIDTH*REDUCED_HEIGHT bytes per frame, in raster order, which is the stream the Gaussian blur stage consumes.

Parameters:
WIDTH, 720, full image width in pixels
HEIGHT, 540, full image height in pixels
STARTING_X, 160, first ROI column (full-image coordinates)
STARTING_Y, 270, first ROI row (full-image coordinates)
REDUCED_WIDTH, 400, ROI width; STARTING_X+REDUCED_WIDTH <= WIDTH
REDUCED_HEIGHT, 270, ROI height; STARTING_Y+REDUCED_HEIGHT <= HEIGHT

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
in_rd_en  out  1  pop upstream FIFO
in_empty  in  1  upstream FIFO empty
in_dout  in  24  pixel: [23:16]=R, [15:8]=G, [7:0]=B
out_wr_en  out  1  push downstream FIFO
out_full  in  1  downstream FIFO full
out_din  out  8  grayscale ROI pixel
frame_done  out  1  one-cycle pulse when the last pixel of a frame is read

Behaviour:
- Reset is decided as: reset reset, asynchronous, active-high; clock clock.
- Reset values: x=0, y=0, hold_valid=0, hold_data=0, frame_done=0. While reset is high, in_rd_en=0 and out_wr_en=0.
- State: x counter (clog2(WIDTH) bits), y counter (clog2(HEIGHT) bits), and a one-entry output holding register (hold_valid, hold_data).
- out_wr_en = hold_valid & !out_full. out_din = hold_data at all times.
- can_accept = !hold_valid | !out_full.
- in_rd_en = !in_empty & can_accept. Every read consumes one pixel, whether it is in or out of the ROI.
- Out-of-ROI pixels are still gated by can_accept. A stalled holding register blocks all reads.
- Gray value = (R+G+B)/3 on a 10-bit sum, truncated. The result is at most 255, so no saturation logic is needed.
- in_roi = (x >= STARTING_X) & (x < STARTING_X+REDUCED_WIDTH) & (y >= STARTING_Y) & (y < STARTING_Y+REDUCED_HEIGHT), evaluated on the x,y of the pixel being read.
- Holding register update at posedge:
  - On a read with in_roi: hold_data <= gray, hold_valid <= 1.
  - Else if out_wr_en: hold_valid <= 0.
  - Simultaneous write-out and in-ROI read: the old value is written and the new value is loaded in the same cycle. Throughput is 1 pixel/cycle.
- Latency: an in-ROI pixel read at edge N is presented with out_wr_en=1 in the cycle after edge N, provided out_full=0.
- Counters advance only on reads:
  - x increments; at x=WIDTH-1, x wraps to 0 and y increments.
  - At (WIDTH-1, HEIGHT-1), both wrap to 0.
  - No reads means the counters hold.
- frame_done is registered. It is 1 for exactly the one cycle after the read of pixel (WIDTH-1, HEIGHT-1), otherwise 0.
- Back-to-back frames need no gap. The next read after the wrap is pixel (0,0) of the new frame.
- Reset mid-frame: counters return to (0,0) and any held pixel is discarded, not written. The next read is treated as pixel (0,0).
- out_full rising while hold_valid=1: out_din and hold_valid are held stable and no reads occur until out_full falls.
- in_empty toggling has no effect other than gating reads. Pixel-to-coordinate mapping must never slip.

Test Plan:
(Bench parameters: WIDTH=8, HEIGHT=6, STARTING_X=2, STARTING_Y=1, REDUCED_WIDTH=4, REDUCED_HEIGHT=3.)
1. Stream one 48-pixel frame with pixel k = {R=k, G=k, B=k}, out_full=0 -> exactly 12 writes with values 10,11,12,13,18,19,20,21,26,27,28,29 in that order; frame_done high exactly once, the cycle after the 48th read.
2. Arithmetic: ROI pixel 0xFFFFFF -> 0xFF; 0x010100 -> 0x00; 0x1E3C5A -> 0x3C; out-of-ROI pixel 0xFFFFFF -> no write.
3. Backpressure: assert out_full for 5 cycles while hold_valid=1 and in_empty=0 -> in_rd_en=0 and out_din stable for all 5 cycles. After release, writes resume with no loss or duplication; the frame still totals 12 writes.
4. Random in_empty bubbles (50%) across 2 back-to-back frames -> 24 writes, the output sequence identical to scenario 1 repeated twice, and 2 frame_done pulses.
5. Assert reset after 20 reads with hold_valid=1, then stream a full frame -> the held pixel is never written; the output matches scenario 1 exactly.
6. Last ROI pixel (5,3) read with out_full=1 on the following cycles -> the value 29 is held, then written once when out_full=0; frame_done timing is unaffected.
